// File: rtl/sample_voice_reader_if.sv
// Voice reader bus: sample tick/gate/address in, BRAM read port, scaled sample out.
// SAMPLE_VOICE_PEAK_HOLD_EN adds the peak_out magnitude tracker signal.
interface sample_voice_reader_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int ENV_WIDTH  = 8
);
    logic                         sample_tick;
    logic                         gate_in;
    logic        [ADDR_WIDTH-1:0] sample_addr_in;
    logic        [ADDR_WIDTH-1:0] bram_addr_out;
    logic                         bram_en_out;
    logic signed [DATA_WIDTH-1:0] bram_data_in;
    logic signed [DATA_WIDTH-1:0] sample_out;
    logic                         sample_valid_out;
    logic        [ENV_WIDTH-1:0]  env_level_out;
    logic                         voice_active_out;
`ifdef SAMPLE_VOICE_PEAK_HOLD_EN
    logic        [DATA_WIDTH-2:0] peak_out;
`endif

    modport slave (
        input  sample_tick, gate_in, sample_addr_in, bram_data_in,
        output bram_addr_out, bram_en_out, sample_out, sample_valid_out,
               env_level_out, voice_active_out
`ifdef SAMPLE_VOICE_PEAK_HOLD_EN
        , output peak_out
`endif
    );

    modport master (
        output sample_tick, gate_in, sample_addr_in, bram_data_in,
        input  bram_addr_out, bram_en_out, sample_out, sample_valid_out,
               env_level_out, voice_active_out
`ifdef SAMPLE_VOICE_PEAK_HOLD_EN
        , input peak_out
`endif
    );
endinterface

// File: rtl/sample_voice_reader.sv
// Per-voice sample reader: BRAM fetch on each tick, ASR envelope scaling, valid-strobed output.
// Optional SAMPLE_VOICE_PEAK_HOLD_EN tracks peak |sample_out| since the last note start.
module sample_voice_reader #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 16,
    parameter int BRAM_LATENCY = 2,
    parameter int ENV_WIDTH    = 8,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 32
) (
    input logic                  clk_in,
    input logic                  rst_in,
    sample_voice_reader_if.slave bus
);
    localparam int L = BRAM_LATENCY;
    localparam logic [ENV_WIDTH-1:0] LVL_MAX = '1;
    localparam logic [ENV_WIDTH:0]   ASTEP   = (ENV_WIDTH+1)'(ATTACK_STEP);
    localparam logic [ENV_WIDTH-1:0] RSTEP   = ENV_WIDTH'(RELEASE_STEP);

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    state_t                       state_q, state_d;
    logic        [ENV_WIDTH-1:0]  level_q, level_d, lvl_inc, lvl_dec, inc_base;
    logic        [ENV_WIDTH:0]    lvl_sum;
    logic                         launch_d, read_d, go_up, go_dn;
    logic                         active_q, bram_en_q, sample_vld_q;
    logic        [ADDR_WIDTH-1:0] bram_addr_q;
    logic signed [DATA_WIDTH-1:0] held_q, sample_q, src;
    logic signed [DATA_WIDTH+ENV_WIDTH:0] prod;
    logic        [L:0]                vld_pipe, rd_pipe;
    logic        [L:0][ENV_WIDTH-1:0] lvl_pipe;

    // A note always starts from level 0, even if level_q were stale.
    always_comb begin
        inc_base = (state_q == IDLE) ? '0 : level_q;
        lvl_sum  = {1'b0, inc_base} + ASTEP;
        lvl_inc  = (lvl_sum > {1'b0, LVL_MAX}) ? LVL_MAX : lvl_sum[ENV_WIDTH-1:0];
        lvl_dec  = (level_q < RSTEP) ? '0 : level_q - RSTEP;
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        launch_d = 1'b0;
        read_d   = 1'b0;
        go_up    = 1'b0;
        go_dn    = 1'b0;
        case (state_q)
            IDLE: if (bus.gate_in) begin
                state_d = ATTACK;
                level_d = '0;
                go_up   = bus.sample_tick;
            end
            ATTACK, SUSTAIN: if (!bus.gate_in) begin
                state_d = RELEASE;
                go_dn   = bus.sample_tick;
            end else begin
                go_up   = bus.sample_tick;
            end
            RELEASE: if (bus.gate_in) begin
                state_d = ATTACK;
                go_up   = bus.sample_tick;
            end else begin
                go_dn   = bus.sample_tick;
            end
            default: state_d = IDLE;
        endcase
        if (go_up) begin
            level_d  = lvl_inc;
            launch_d = 1'b1;
            read_d   = 1'b1;
            state_d  = (lvl_inc == LVL_MAX) ? SUSTAIN : ATTACK;
        end
        if (go_dn) begin
            level_d  = lvl_dec;
            launch_d = 1'b1;
            state_d  = (lvl_dec == '0) ? IDLE : RELEASE;
        end
    end

    // Release ticks rescale the last fetched sample instead of reading BRAM.
    always_comb begin
        src  = rd_pipe[L] ? bus.bram_data_in : held_q;
        prod = (DATA_WIDTH+ENV_WIDTH+1)'(src) *
               (DATA_WIDTH+ENV_WIDTH+1)'($signed({1'b0, lvl_pipe[L]}));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            level_q      <= '0;
            active_q     <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            held_q       <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            vld_pipe     <= '0;
            rd_pipe      <= '0;
            lvl_pipe     <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            active_q    <= (state_d != IDLE);
            bram_en_q   <= read_d;
            if (read_d)
                bram_addr_q <= bus.sample_addr_in;
            vld_pipe[0] <= launch_d;
            rd_pipe[0]  <= read_d;
            lvl_pipe[0] <= level_d;
            for (int i = 1; i <= L; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
                lvl_pipe[i] <= lvl_pipe[i-1];
            end
            sample_vld_q <= vld_pipe[L];
            if (vld_pipe[L]) begin
                sample_q <= DATA_WIDTH'(prod >>> ENV_WIDTH);
                if (rd_pipe[L])
                    held_q <= bus.bram_data_in;
            end
        end
    end

    assign bus.bram_en_out      = bram_en_q;
    assign bus.bram_addr_out    = bram_addr_q;
    assign bus.sample_out       = sample_q;
    assign bus.sample_valid_out = sample_vld_q;
    assign bus.env_level_out    = level_q;
    assign bus.voice_active_out = active_q;

`ifdef SAMPLE_VOICE_PEAK_HOLD_EN
    logic [DATA_WIDTH-2:0] peak_q, mag;

    // The most negative sample has no positive twin; clamp it to all ones.
    always_comb begin
        if (!sample_q[DATA_WIDTH-1])
            mag = sample_q[DATA_WIDTH-2:0];
        else if (sample_q == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            mag = '1;
        else
            mag = (DATA_WIDTH-1)'(-sample_q);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in || (state_q == IDLE && state_d != IDLE))
            peak_q <= '0;
        else if (sample_vld_q && mag > peak_q)
            peak_q <= mag;
    end

    assign bus.peak_out = peak_q;
`endif
endmodule

// File: doc/sample_voice_reader.md
Name: sample_voice_reader

Overview:
- Downstream consumer of the per-voice sample address counter.
- On each sample_tick it issues a read of sample_addr_in to the sample BRAM and waits out the BRAM read latency.
- It scales the returned sample by an attack/sustain/release envelope driven by gate_in and emits one signed audio sample per tick with a valid strobe.
- Output feeds the voice mixer.

Parameters:
ADDR_WIDTH, 13, sample address width (BRAM depth 8192)
DATA_WIDTH, 16, signed sample width
BRAM_LATENCY, 2, cycles from bram_en_out high to bram_data_in valid (>=1)
ENV_WIDTH, 8, envelope level width; max level = 2^ENV_WIDTH-1
ATTACK_STEP, 64, level increment per tick in ATTACK
RELEASE_STEP, 32, level decrement per tick in RELEASE

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low (0 = reset)
sample_tick  input  1  one-cycle sample-rate strobe
gate_in  input  1  note on (1) / off (0)
sample_addr_in  input  ADDR_WIDTH  current address from address counter
bram_addr_out  output  ADDR_WIDTH  BRAM read address (registered)
bram_en_out  output  1  BRAM read enable, one-cycle pulse
bram_data_in  input  DATA_WIDTH  BRAM read data, signed
sample_out  output  DATA_WIDTH  scaled sample, signed, registered
sample_valid_out  output  1  one-cycle strobe, sample_out is new
env_level_out  output  ENV_WIDTH  current envelope level
voice_active_out  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_in=0 at a clock edge): all outputs 0, state IDLE, level 0, held sample 0, in-flight pipeline entries dropped.
- Envelope FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE -> ATTACK when gate_in=1, evaluated every cycle; level starts at 0.
  - ATTACK: on each tick, level += ATTACK_STEP, saturating at max; -> SUSTAIN when max is reached.
  - SUSTAIN: level held at max.
  - ATTACK/SUSTAIN -> RELEASE in the first cycle gate_in=0 is observed, no tick required.
  - RELEASE: on each tick, level -= RELEASE_STEP, saturating at 0; -> IDLE on the tick that reaches 0, after that tick's sample is launched.
  - RELEASE -> ATTACK if gate_in=1; level continues from its current value (no jump to 0).
- Level update and launch order: on a tick, the level is updated first; the launched sample carries the updated level through the pipeline.
- Read launch: a tick at cycle T in ATTACK or SUSTAIN gives bram_en_out=1 and bram_addr_out=sample_addr_in at T+1.
- Data capture: bram_data_in is captured into the held-sample register at T+1+BRAM_LATENCY.
- Output timing: sample_out and sample_valid_out=1 at T+2+BRAM_LATENCY.
- RELEASE: no BRAM reads. Each tick scales the held sample (last captured) by the new level, with the same T+2+BRAM_LATENCY latency.
- IDLE: ticks ignored; no reads, no valid; sample_out holds 0.
- Pipelining: a tick is accepted every cycle. The pipeline is a shift register of valid+level (+read flag); outputs leave in tick order.
- Arithmetic: signed sample times zero-extended level gives a DATA_WIDTH+ENV_WIDTH+1 product. Arithmetic shift right by ENV_WIDTH, take the low DATA_WIDTH bits. No overflow is possible.
- Simultaneous tick and gate fall in ATTACK/SUSTAIN: RELEASE takes effect that cycle; the tick is handled as a RELEASE tick.
- Simultaneous tick and gate rise in IDLE: enter ATTACK and process the tick (level = ATTACK_STEP, read launched).
- Reset mid-operation: pipeline flushed; no sample_valid_out after the reset edge.

Optional Feature:
- Macro: SAMPLE_VOICE_PEAK_HOLD_EN.
- Defined: extra output peak_out (DATA_WIDTH-1 bits, unsigned) holding max |sample_out| seen since the last IDLE->ATTACK transition.
  - Updated the cycle after each sample_valid_out.
  - Cleared on reset and on IDLE->ATTACK.
  - |-2^(DATA_WIDTH-1)| saturates to all ones.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles during active playback -> all outputs 0, voice_active_out=0; no valid strobes on the cycles after reset even with ticks in flight.
- Attack (BRAM always returns 0x4000, ticks every 10 cycles, gate=1) -> env levels 64,128,192,255 then SUSTAIN; sample_out 0x1000,0x2000,0x3000,0x3FC0; each valid exactly 4 cycles after its tick; bram_en_out 1 cycle after tick.
- Release (from SUSTAIN with held 0x4000, gate->0) -> no bram_en_out; levels 223,191,...,31,0; first sample_out 0x37C0, last 0x0000 with valid; then IDLE, no further valids.
- Retrigger during RELEASE at level 191, gate->1 -> next tick level 255 (saturated), state SUSTAIN, reads resume at the current sample_addr_in.
- Negative data 0x8000 at level 128 -> sample_out 0xC000.
- Back-to-back ticks every cycle, addresses 0..7 -> sample_valid_out high 8 consecutive cycles, outputs in address order.
